// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM, the instruction decoder and the bench.
// Optional performance counters are built with MULTICYCLE_PERF_CNT_EN (see multicycle_ctrl.sv).
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5,
      ST_ERROR  = 3'd6
   } state_e;

   localparam logic [1:0] OPC_DP  = 2'b00;
   localparam logic [1:0] OPC_MEM = 2'b01;
   localparam logic [1:0] OPC_BR  = 2'b10;
   localparam logic [1:0] OPC_UND = 2'b11;

   localparam logic WB_SEL_MEM = 1'b0;
   localparam logic WB_SEL_ALU = 1'b1;

   localparam logic PC_SRC_INC = 1'b0;
   localparam logic PC_SRC_ALU = 1'b1;

   // Every instruction boundary lands in FETCH unless a halt is pending.
   function automatic state_e boundary_next(input logic halt_req);
      return halt_req ? ST_HALT : ST_FETCH;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Decoder-to-controller and controller-to-datapath signal bundle.
// Performance counter outputs exist only when MULTICYCLE_PERF_CNT_EN is defined.
interface multicycle_ctrl_if;

   logic [1:0] op_in;
   logic       load_in;
   logic       cond_pass_in;
   logic       set_flags_in;
   logic       halt_req_in;
   logic       mem_ready_in;

   logic       ir_write_en_out;
   logic       pc_write_en_out;
   logic       pc_src_sel_out;
   logic       imem_req_out;
   logic       dmem_req_out;
   logic       dmem_write_en_out;
   logic       reg_write_en_out;
   logic       wb_sel_out;
   logic       flag_write_en_out;
   logic       branch_sel_out;
   logic [2:0] state_out;
   logic       halted_out;
   logic       err_out;
`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0] retired_cnt_out;
   logic [31:0] stall_cnt_out;
`endif

   modport master (
      input  op_in, load_in, cond_pass_in, set_flags_in, halt_req_in, mem_ready_in,
      output ir_write_en_out, pc_write_en_out, pc_src_sel_out, imem_req_out,
             dmem_req_out, dmem_write_en_out, reg_write_en_out, wb_sel_out,
             flag_write_en_out, branch_sel_out, state_out, halted_out, err_out
`ifdef MULTICYCLE_PERF_CNT_EN
      , output retired_cnt_out, stall_cnt_out
`endif
   );

   modport slave (
      output op_in, load_in, cond_pass_in, set_flags_in, halt_req_in, mem_ready_in,
      input  ir_write_en_out, pc_write_en_out, pc_src_sel_out, imem_req_out,
             dmem_req_out, dmem_write_en_out, reg_write_en_out, wb_sel_out,
             flag_write_en_out, branch_sel_out, state_out, halted_out, err_out
`ifdef MULTICYCLE_PERF_CNT_EN
      , input retired_cnt_out, stall_cnt_out
`endif
   );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory-wait counter shared by FETCH and MEM; flags the last permitted wait cycle.
// Unaffected by MULTICYCLE_PERF_CNT_EN.
module multicycle_ctrl_mem_wait_timer #(
   parameter int TIMEOUT_W   = 4,
   parameter int MEM_TIMEOUT = 12
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic clr_in,
   input  logic inc_in,
   output logic timeout_out
);

   localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(MEM_TIMEOUT - 1);

   logic [TIMEOUT_W-1:0] cnt_d;
   logic [TIMEOUT_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_in) begin
         cnt_d = '0;
      end else if (inc_in) begin
         cnt_d = cnt_q + TIMEOUT_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // High during the MEM_TIMEOUT-th consecutive wait cycle of the current state.
   assign timeout_out = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback and gates all write enables.
// Define MULTICYCLE_PERF_CNT_EN to add retired-instruction and memory-stall counters.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int TIMEOUT_W   = 4,
   parameter int MEM_TIMEOUT = 12
) (
   input  logic             clk_in,
   input  logic             rst_in,
   multicycle_ctrl_if.master bus
);

   state_e state_d;
   state_e state_q;

   logic ir_we;
   logic pc_we;
   logic pc_src;
   logic imem_req;
   logic dmem_req;
   logic dmem_we;
   logic reg_we;
   logic wb_sel;
   logic flag_we;
   logic branch_sel;
   logic halted;
   logic err;

   logic wait_evt;
   logic timer_clr;
   logic timeout;

   assign wait_evt  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready_in;
   assign timer_clr = (state_d != state_q);

   multicycle_ctrl_mem_wait_timer #(
      .TIMEOUT_W   (TIMEOUT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clr_in      (timer_clr),
      .inc_in      (wait_evt),
      .timeout_out (timeout)
   );

   always_comb begin
      state_d    = state_q;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = PC_SRC_INC;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = WB_SEL_MEM;
      flag_we    = 1'b0;
      branch_sel = 1'b0;
      halted     = 1'b0;
      err        = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            imem_req = 1'b1;
            if (bus.mem_ready_in) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               pc_src  = PC_SRC_INC;
               state_d = ST_DECODE;
            end else if (timeout) begin
               state_d = ST_ERROR;
            end
         end
         ST_DECODE: begin
            if (bus.op_in == OPC_UND) begin
               state_d = ST_ERROR;
            end else if (!bus.cond_pass_in) begin
               state_d = boundary_next(bus.halt_req_in);
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            branch_sel = (bus.op_in == OPC_BR);
            unique case (bus.op_in)
               OPC_DP: begin
                  flag_we = bus.set_flags_in;
                  state_d = ST_WB;
               end
               OPC_BR: begin
                  pc_we   = 1'b1;
                  pc_src  = PC_SRC_ALU;
                  state_d = boundary_next(bus.halt_req_in);
               end
               OPC_MEM: state_d = ST_MEM;
               default: state_d = ST_ERROR;
            endcase
         end
         ST_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = !bus.load_in;
            if (bus.mem_ready_in) begin
               state_d = bus.load_in ? ST_WB : boundary_next(bus.halt_req_in);
            end else if (timeout) begin
               state_d = ST_ERROR;
            end
         end
         ST_WB: begin
            reg_we  = 1'b1;
            wb_sel  = (bus.op_in == OPC_DP) ? WB_SEL_ALU : WB_SEL_MEM;
            state_d = boundary_next(bus.halt_req_in);
         end
         ST_HALT: begin
            halted = 1'b1;
            if (!bus.halt_req_in) begin
               state_d = ST_FETCH;
            end
         end
         ST_ERROR: begin
            err = 1'b1;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase

      // A reset cycle must never commit architectural state, whatever state we were in.
      if (rst_in) begin
         ir_we      = 1'b0;
         pc_we      = 1'b0;
         pc_src     = PC_SRC_INC;
         dmem_req   = 1'b0;
         dmem_we    = 1'b0;
         reg_we     = 1'b0;
         wb_sel     = WB_SEL_MEM;
         flag_we    = 1'b0;
         branch_sel = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus.ir_write_en_out   = ir_we;
   assign bus.pc_write_en_out   = pc_we;
   assign bus.pc_src_sel_out    = pc_src;
   assign bus.imem_req_out      = imem_req;
   assign bus.dmem_req_out      = dmem_req;
   assign bus.dmem_write_en_out = dmem_we;
   assign bus.reg_write_en_out  = reg_we;
   assign bus.wb_sel_out        = wb_sel;
   assign bus.flag_write_en_out = flag_we;
   assign bus.branch_sel_out    = branch_sel;
   assign bus.state_out         = state_q;
   assign bus.halted_out        = halted;
   assign bus.err_out           = err;

`ifdef MULTICYCLE_PERF_CNT_EN
   logic        retire_evt;
   logic [31:0] retired_cnt_d;
   logic [31:0] retired_cnt_q;
   logic [31:0] stall_cnt_d;
   logic [31:0] stall_cnt_q;

   // An instruction retires when EXEC/MEM/WB hands back to the boundary (a pending halt still retires it).
   assign retire_evt = ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)) &&
                       ((state_d == ST_FETCH) || (state_d == ST_HALT));

   always_comb begin
      retired_cnt_d = retired_cnt_q;
      stall_cnt_d   = stall_cnt_q;
      if (retire_evt) begin
         retired_cnt_d = retired_cnt_q + 32'd1;
      end
      if (wait_evt) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         retired_cnt_q <= '0;
         stall_cnt_q   <= '0;
      end else begin
         retired_cnt_q <= retired_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign bus.retired_cnt_out = retired_cnt_q;
   assign bus.stall_cnt_out   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; counter checks are active with MULTICYCLE_PERF_CNT_EN.
module tb_multicycle_ctrl;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;

   always #5 clk_in = ~clk_in;

   multicycle_ctrl_if bus ();

   multicycle_ctrl u_dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic ready_base = 1'b0;
   int   dmem_wait  = 0;

   int   m_pc = 0, m_pcalu = 0, m_reg = 0, m_flag = 0, m_dwe = 0, m_bsel = 0, m_mem = 0, m_ir = 0;
   logic m_wb = 1'b0;

   int   s_pc, s_pcalu, s_reg, s_flag, s_dwe, s_bsel, s_mem, s_ir;
`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0] s_ret, s_stall;
`endif

   logic [63:0] seq;
   int          cyc;

   // Strobe tallies taken mid-cycle, once per cycle.
   always @(negedge clk_in) begin
      if (bus.pc_write_en_out === 1'b1) m_pc++;
      if (bus.pc_write_en_out === 1'b1 && bus.pc_src_sel_out === 1'b1) m_pcalu++;
      if (bus.reg_write_en_out === 1'b1) begin
         m_reg++;
         m_wb = bus.wb_sel_out;
      end
      if (bus.flag_write_en_out === 1'b1) m_flag++;
      if (bus.dmem_write_en_out === 1'b1) m_dwe++;
      if (bus.branch_sel_out === 1'b1) m_bsel++;
      if (bus.state_out === 3'd3) m_mem++;
      if (bus.ir_write_en_out === 1'b1) m_ir++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      if (bus.state_out == 3'd3 && dmem_wait > 0) begin
         bus.mem_ready_in = 1'b0;
         dmem_wait--;
      end else begin
         bus.mem_ready_in = ready_base;
      end
      #1;
   endtask

   task automatic snap();
      s_pc = m_pc; s_pcalu = m_pcalu; s_reg = m_reg; s_flag = m_flag;
      s_dwe = m_dwe; s_bsel = m_bsel; s_mem = m_mem; s_ir = m_ir;
`ifdef MULTICYCLE_PERF_CNT_EN
      s_ret = bus.retired_cnt_out; s_stall = bus.stall_cnt_out;
`endif
   endtask

   task automatic run_instr(output logic [63:0] sq, output int n);
      sq = 64'(bus.state_out);
      n  = 0;
      do begin
         tick();
         n++;
         sq = (sq << 4) | 64'(bus.state_out);
      end while (bus.state_out != 3'd0 && bus.state_out != 3'd5 && bus.state_out != 3'd6 && n < 40);
   endtask

   task automatic set_instr(input logic [1:0] op, input logic ld, input logic cp, input logic sf);
      bus.op_in = op; bus.load_in = ld; bus.cond_pass_in = cp; bus.set_flags_in = sf;
   endtask

   initial begin
      set_instr(2'b00, 1'b0, 1'b0, 1'b0);
      bus.halt_req_in  = 1'b0;
      bus.mem_ready_in = 1'b0;

      // reset
      tick(); tick();
      rst_in = 1'b0;
      #1;
      chk("rst_state", 64'(bus.state_out), 64'd0);
      chk("rst_imem_req", 64'(bus.imem_req_out), 64'd1);
      chk("rst_ir_we", 64'(bus.ir_write_en_out), 64'd0);
      chk("rst_err", 64'(bus.err_out), 64'd0);
      chk("rst_halted", 64'(bus.halted_out), 64'd0);

      // data-proc ADD with S=1, zero-wait memory
      set_instr(2'b00, 1'b0, 1'b1, 1'b1);
      ready_base = 1'b1; bus.mem_ready_in = 1'b1;
      snap();
      run_instr(seq, cyc);
      chk("dp_seq", seq, 64'h01240);
      chk("dp_cycles", 64'(cyc), 64'd4);
      chk("dp_pc_pulses", 64'(m_pc - s_pc), 64'd1);
      chk("dp_reg_we", 64'(m_reg - s_reg), 64'd1);
      chk("dp_flag_we", 64'(m_flag - s_flag), 64'd1);
      chk("dp_wb_sel", 64'(m_wb), 64'd1);
      chk("dp_ir_we", 64'(m_ir - s_ir), 64'd1);
`ifdef MULTICYCLE_PERF_CNT_EN
      chk("dp_retired", 64'(bus.retired_cnt_out - s_ret), 64'd1);
`endif

      // load with three MEM wait cycles
      set_instr(2'b01, 1'b1, 1'b1, 1'b0);
      dmem_wait = 3;
      snap();
      run_instr(seq, cyc);
      chk("ldr_seq", seq, 64'h012333340);
      chk("ldr_cycles", 64'(cyc), 64'd8);
      chk("ldr_mem_cycles", 64'(m_mem - s_mem), 64'd4);
      chk("ldr_reg_we", 64'(m_reg - s_reg), 64'd1);
      chk("ldr_wb_sel", 64'(m_wb), 64'd0);
      chk("ldr_no_store", 64'(m_dwe - s_dwe), 64'd0);
      chk("ldr_pc_pulses", 64'(m_pc - s_pc), 64'd1);
`ifdef MULTICYCLE_PERF_CNT_EN
      chk("ldr_stalls", 64'(bus.stall_cnt_out - s_stall), 64'd3);
`endif

      // branch squashed by condition
      set_instr(2'b10, 1'b0, 1'b0, 1'b1);
      snap();
      run_instr(seq, cyc);
      chk("bsq_seq", seq, 64'h010);
      chk("bsq_cycles", 64'(cyc), 64'd2);
      chk("bsq_pc_pulses", 64'(m_pc - s_pc), 64'd1);
      chk("bsq_pc_alu", 64'(m_pcalu - s_pcalu), 64'd0);
      chk("bsq_reg_we", 64'(m_reg - s_reg), 64'd0);
      chk("bsq_flag_we", 64'(m_flag - s_flag), 64'd0);

      // taken branch
      set_instr(2'b10, 1'b0, 1'b1, 1'b1);
      snap();
      run_instr(seq, cyc);
      chk("br_seq", seq, 64'h0120);
      chk("br_cycles", 64'(cyc), 64'd3);
      chk("br_pc_pulses", 64'(m_pc - s_pc), 64'd2);
      chk("br_pc_alu", 64'(m_pcalu - s_pcalu), 64'd1);
      chk("br_sel", 64'(m_bsel - s_bsel), 64'd1);
      chk("br_flag_we", 64'(m_flag - s_flag), 64'd0);

      // store with halt requested mid-instruction
      set_instr(2'b01, 1'b0, 1'b1, 1'b0);
      snap();
      tick();
      chk("st_decode", 64'(bus.state_out), 64'd1);
      bus.halt_req_in = 1'b1;
      tick();
      chk("st_exec", 64'(bus.state_out), 64'd2);
      tick();
      chk("st_mem_req", 64'(bus.dmem_req_out), 64'd1);
      chk("st_mem_we", 64'(bus.dmem_write_en_out), 64'd1);
      tick();
      chk("st_halt_state", 64'(bus.state_out), 64'd5);
      chk("st_halted", 64'(bus.halted_out), 64'd1);
      chk("st_halt_imem", 64'(bus.imem_req_out), 64'd0);
      tick();
      chk("st_halt_hold", 64'(bus.state_out), 64'd5);
      bus.halt_req_in = 1'b0;
      tick();
      chk("st_resume", 64'(bus.state_out), 64'd0);
      chk("st_resume_halted", 64'(bus.halted_out), 64'd0);
      chk("st_store_strobes", 64'(m_dwe - s_dwe), 64'd1);
      chk("st_reg_we", 64'(m_reg - s_reg), 64'd0);

      // ready arriving on the last permitted wait cycle wins over timeout
      set_instr(2'b00, 1'b0, 1'b0, 1'b0);
      ready_base = 1'b0; bus.mem_ready_in = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      chk("rw_still_fetch", 64'(bus.state_out), 64'd0);
      ready_base = 1'b1; bus.mem_ready_in = 1'b1;
      #1;
      chk("rw_ir_we", 64'(bus.ir_write_en_out), 64'd1);
      tick();
      chk("rw_decode", 64'(bus.state_out), 64'd1);
      tick();
      chk("rw_back_fetch", 64'(bus.state_out), 64'd0);

      // fetch timeout
      set_instr(2'b00, 1'b0, 1'b1, 1'b1);
      ready_base = 1'b0; bus.mem_ready_in = 1'b0;
      for (int i = 0; i < 11; i++) tick();
      chk("to_fetch_11", 64'(bus.state_out), 64'd0);
      chk("to_err_early", 64'(bus.err_out), 64'd0);
      tick();
      chk("to_error_state", 64'(bus.state_out), 64'd6);
      chk("to_err", 64'(bus.err_out), 64'd1);
      ready_base = 1'b1;
      snap();
      for (int i = 0; i < 3; i++) tick();
      chk("to_hold_state", 64'(bus.state_out), 64'd6);
      chk("to_hold_imem", 64'(bus.imem_req_out), 64'd0);
      chk("to_hold_pc", 64'(m_pc - s_pc), 64'd0);
      chk("to_hold_ir", 64'(m_ir - s_ir), 64'd0);
      chk("to_hold_reg", 64'(m_reg - s_reg), 64'd0);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      #1;
      chk("to_rst_state", 64'(bus.state_out), 64'd0);
      chk("to_rst_err", 64'(bus.err_out), 64'd0);

      // undefined op
      set_instr(2'b11, 1'b0, 1'b1, 1'b0);
      bus.mem_ready_in = 1'b1;
      run_instr(seq, cyc);
      chk("und_seq", seq, 64'h016);
      chk("und_err", 64'(bus.err_out), 64'd1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;

      // reset while a store waits in MEM
      set_instr(2'b01, 1'b0, 1'b1, 1'b0);
      bus.mem_ready_in = 1'b1;
      dmem_wait = 5;
      tick(); tick(); tick();
      chk("rm_mem_state", 64'(bus.state_out), 64'd3);
      chk("rm_we_before", 64'(bus.dmem_write_en_out), 64'd1);
      rst_in = 1'b1;
      #1;
      chk("rm_we_in_rst", 64'(bus.dmem_write_en_out), 64'd0);
      chk("rm_req_in_rst", 64'(bus.dmem_req_out), 64'd0);
      tick();
      rst_in = 1'b0;
      dmem_wait = 0;
      #1;
      chk("rm_after_state", 64'(bus.state_out), 64'd0);
`ifdef MULTICYCLE_PERF_CNT_EN
      chk("rm_ret_clr", 64'(bus.retired_cnt_out), 64'd0);
      chk("rm_stall_clr", 64'(bus.stall_cnt_out), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
